// File: rtl/fdiv_core.sv
// fdiv_core: iterative IEEE-754 binary32 divider with AXI-Stream operand and
// result channels. Produces one quotient bit per clock by restoring division;
// special operands bypass the iteration and answer one edge after capture.
`timescale 1ns/1ps
module fdiv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_b_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    output logic [31:0] m_axis_result_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready
);

    localparam int QBITS = 26;
    localparam int BIAS  = 127;

    // cnt walks 0..QBITS-1 while quotient bits are produced; the value QBITS
    // marks the final normalise/round/pack edge.
    localparam logic [4:0] CNT_PACK = 5'(QBITS);
    localparam logic signed [9:0] EXP_BIAS = 10'(BIAS);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        a_held, b_held;
    logic        a_fire, b_fire;
    logic [4:0]  cnt;

    logic [31:0] opa_p0, opb_p0;
    logic [25:0] rem_p1;
    logic [25:0] quo_p1;
    logic [31:0] res_p2;
    logic        vld_p2;

    // operand classification
    logic        a_nan, a_inf, a_zero;
    logic        b_nan, b_inf, b_zero;
    logic        res_sign;
    logic        special;
    logic [31:0] special_res;

    // one restoring-division step
    logic [25:0]        rem_cur;
    logic [25:0]        rem_nxt;
    logic signed [26:0] trial;
    logic               qbit;

    // Normalise the 26-bit quotient, round to nearest even and pack. Results
    // that round past the largest exponent become infinity; anything that
    // would need a denormal encoding is flushed to signed zero.
    function automatic logic [31:0] round_pack(
        input logic        sign,
        input logic [7:0]  ea,
        input logic [7:0]  eb,
        input logic [25:0] q,
        input logic        rem_nz
    );
        logic signed [9:0] e;
        logic [25:0]       qn;
        logic [24:0]       mant;
        logic              guard;
        logic              sticky;
        e  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;
        qn = q;
        if (!q[25]) begin
            qn = {q[24:0], 1'b0};
            e  = e - 10'sd1;
        end
        mant   = {1'b0, qn[25:2]};
        guard  = qn[1];
        sticky = qn[0] | rem_nz;
        if (guard & (sticky | mant[0]))
            mant = mant + 25'd1;
        if (mant[24]) begin
            mant = 25'h080_0000;
            e    = e + 10'sd1;
        end
        if (e >= 10'sd255)
            return {sign, 8'hFF, 23'd0};
        if (e <= 10'sd0)
            return {sign, 31'd0};
        return {sign, e[7:0], mant[22:0]};
    endfunction

    assign a_fire = s_axis_a_tvalid & s_axis_a_tready;
    assign b_fire = s_axis_b_tvalid & s_axis_b_tready;

    // Classify held operands; denormals count as zero.
    always_comb begin
        a_nan    = (opa_p0[30:23] == 8'hFF) && (opa_p0[22:0] != 23'd0);
        a_inf    = (opa_p0[30:23] == 8'hFF) && (opa_p0[22:0] == 23'd0);
        a_zero   = (opa_p0[30:23] == 8'h00);
        b_nan    = (opb_p0[30:23] == 8'hFF) && (opb_p0[22:0] != 23'd0);
        b_inf    = (opb_p0[30:23] == 8'hFF) && (opb_p0[22:0] == 23'd0);
        b_zero   = (opb_p0[30:23] == 8'h00);
        res_sign = opa_p0[31] ^ opb_p0[31];
        special  = 1'b1;
        if (a_nan || b_nan)
            special_res = QNAN;
        else if ((a_zero && b_zero) || (a_inf && b_inf))
            special_res = QNAN;
        else if (a_inf || b_zero)
            special_res = {res_sign, 8'hFF, 23'd0};
        else if (a_zero || b_inf)
            special_res = {res_sign, 31'd0};
        else begin
            special_res = 32'd0;
            special     = 1'b0;
        end
    end

    // Trial subtraction of the divisor mantissa from the partial remainder.
    always_comb begin
        rem_cur = (cnt == 5'd0) ? {2'b00, 1'b1, opa_p0[22:0]} : rem_p1;
        trial   = $signed({1'b0, rem_cur}) - $signed({3'b000, 1'b1, opb_p0[22:0]});
        qbit    = ~trial[26];
        rem_nxt = qbit ? {trial[24:0], 1'b0} : {rem_cur[24:0], 1'b0};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if ((a_held | a_fire) & (b_held | b_fire))
                      state_nxt = DIV;
            DIV:  if (((cnt == 5'd0) && special) || (cnt == CNT_PACK))
                      state_nxt = OUT;
            OUT:  if (vld_p2 & m_axis_result_tready)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: treadys depend on registers only, never on tvalid.
    always_comb begin
        s_axis_a_tready      = (state == IDLE) & ~a_held;
        s_axis_b_tready      = (state == IDLE) & ~b_held;
        m_axis_result_tdata  = res_p2;
        m_axis_result_tvalid = vld_p2;
    end

    // Control: operand-held flags, bit counter and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_held <= 1'b0;
            b_held <= 1'b0;
            cnt    <= 5'd0;
            vld_p2 <= 1'b0;
            res_p2 <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (a_fire)
                        a_held <= 1'b1;
                    if (b_fire)
                        b_held <= 1'b1;
                    cnt <= 5'd0;
                end
                DIV: begin
                    if ((cnt == 5'd0) && special) begin
                        res_p2 <= special_res;
                        vld_p2 <= 1'b1;
                    end else if (cnt == CNT_PACK) begin
                        res_p2 <= round_pack(res_sign, opa_p0[30:23], opb_p0[30:23],
                                             quo_p1, rem_p1 != 26'd0);
                        vld_p2 <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                OUT: begin
                    if (vld_p2 & m_axis_result_tready) begin
                        vld_p2 <= 1'b0;
                        a_held <= 1'b0;
                        b_held <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 0: operand capture on each channel's own handshake.
    always_ff @(posedge clk) begin
        if (a_fire)
            opa_p0 <= s_axis_a_tdata;
        if (b_fire)
            opb_p0 <= s_axis_b_tdata;
    end

    // Stage 1: quotient bits shift in MSB first, remainder kept for sticky.
    always_ff @(posedge clk) begin
        if ((state == DIV) && (cnt != CNT_PACK)) begin
            rem_p1 <= rem_nxt;
            quo_p1 <= {quo_p1[24:0], qbit};
        end
    end

endmodule

// File: tb/tb_fdiv_core.sv
// tb_fdiv_core: scoreboard bench for fdiv_core. The stimulus process pushes
// the expected quotient and latency for each operation; a monitor process pops
// and compares whenever the result channel presents a new value.
`timescale 1ns/1ps
module tb_fdiv_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [31:0] m_data;
    logic        m_vld;
    logic        res_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;
    int ops_sent = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          cap_q[$];

    fdiv_core dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis_a_tdata       (a_data),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_a_tready      (a_ready),
        .s_axis_b_tdata       (b_data),
        .s_axis_b_tvalid      (b_valid),
        .s_axis_b_tready      (b_ready),
        .m_axis_result_tdata  (m_data),
        .m_axis_result_tvalid (m_vld),
        .m_axis_result_tready (res_ready)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference: {is_special, result}. Mantissa quotient is formed with
    // 64-bit integer division, then normalised and rounded to nearest even.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int   ea, eb, e;
        longint unsigned num, den, q, r, mant;
        bit   an, bn, ai, bi, az, bz, g, st;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn)                   return {1'b1, 32'h7FC0_0000};
        if ((az && bz) || (ai && bi))   return {1'b1, 32'h7FC0_0000};
        if (ai || bz)                   return {1'b1, s, 8'hFF, 23'd0};
        if (az || bi)                   return {1'b1, s, 31'd0};
        num = (longint'(a[22:0]) + 64'h80_0000) << 25;
        den = longint'(b[22:0]) + 64'h80_0000;
        q = num / den;
        r = num % den;
        e = ea - eb + 127;
        if (q < (64'd1 << 25)) begin
            q = q * 2;
            e = e - 1;
        end
        mant = q >> 2;
        g    = q[1];
        st   = q[0] | (r != 0);
        if (g && (st || mant[0]))
            mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], mant[22:0]};
    endfunction

    // Issue one division. Each operand goes valid after its own delay (in
    // cycles); acap/bcap are the edge numbers on which each was accepted.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                           input int a_dly, input int b_dly,
                           output int acap, output int bcap);
        logic [32:0] rv;
        bit ad, bd;
        int t;
        rv = ref_div(a, b);
        exp_q.push_back(rv[31:0]);
        lat_q.push_back(rv[32] ? 1 : 27);
        ops_sent = ops_sent + 1;
        ad = 0; bd = 0; t = 0; acap = 0; bcap = 0;
        @(posedge clk); #1;
        if (a_dly == 0) begin a_data = a; a_valid = 1'b1; end
        if (b_dly == 0) begin b_data = b; b_valid = 1'b1; end
        while (!(ad && bd)) begin
            @(negedge clk);
            if (a_valid && a_ready) begin ad = 1; acap = cyc + 1; end
            else if (ad) chk("a_tready_low_while_held", 32'(a_ready), 32'd0);
            if (b_valid && b_ready) begin bd = 1; bcap = cyc + 1; end
            else if (bd) chk("b_tready_low_while_held", 32'(b_ready), 32'd0);
            @(posedge clk); #1;
            if (ad) a_valid = 1'b0;
            if (bd) b_valid = 1'b0;
            t = t + 1;
            if (t == a_dly && !ad) begin a_data = a; a_valid = 1'b1; end
            if (t == b_dly && !bd) begin b_data = b; b_valid = 1'b1; end
            if (t > 300) begin
                timeout_fail("operand_accept");
                a_valid = 1'b0;
                b_valid = 1'b0;
                break;
            end
        end
        cap_q.push_back((acap > bcap) ? acap : bcap);
    endtask

    task automatic wait_result(input int target, input bit rnd);
        int t;
        t = 0;
        while (n_out < target && t < 400) begin
            @(posedge clk); #1;
            if (rnd) res_ready = ($urandom_range(0, 3) != 0);
            t = t + 1;
        end
        if (n_out < target) timeout_fail("result_wait");
        res_ready = 1'b1;
    endtask

    // Monitor: compare each newly presented result against the scoreboard,
    // check latency, and check tdata/tvalid stay stable until accepted.
    initial begin
        logic [31:0] held;
        logic [31:0] e;
        bit          prev_vld, prev_hs;
        int          l, c;
        held = 32'd0; prev_vld = 0; prev_hs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 0;
                prev_hs  = 0;
            end else begin
                if (m_vld && !prev_vld) begin
                    if (exp_q.size() == 0 || cap_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL unexpected_result: got %08h with nothing expected", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        l = lat_q.pop_front();
                        c = cap_q.pop_front();
                        chk("result_data", m_data, e);
                        chk("result_latency", 32'(cyc - c), 32'(l));
                    end
                    held = m_data;
                end else if (m_vld) begin
                    chk("result_hold_data", m_data, held);
                end else if (prev_vld && !prev_hs) begin
                    chk("result_hold_valid", 32'(m_vld), 32'd1);
                end
                prev_hs = m_vld && res_ready;
                if (prev_hs) n_out = n_out + 1;
                prev_vld = m_vld;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] dir_a [11] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
                                32'hC000_0000, 32'h7FC0_0001, 32'h7F7F_FFFF, 32'h0080_0000,
                                32'h8040_0000, 32'h7F80_0000, 32'hC0E0_0000};
    logic [31:0] dir_b [11] = '{32'h4040_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000,
                                32'h7F80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h4000_0000,
                                32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000};

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int k;
        k = $urandom_range(0, 11);
        v = $urandom;
        case (k)
            0: v = {v[31], 31'd0};
            1: v = {v[31], 8'hFF, 23'd0};
            2: v = {v[31], 8'hFF, v[22:0] | 23'd1};
            3: v = {v[31], 8'h00, v[22:0]};
            default: v = {v[31], 8'($urandom_range(1, 254)), v[22:0]};
        endcase
        return v;
    endfunction

    initial begin
        int acap, bcap;
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = 32'd0; b_data = 32'd0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("reset_tvalid", 32'(m_vld), 32'd0);
        chk("reset_tdata", m_data, 32'd0);
        chk("reset_a_tready", 32'(a_ready), 32'd1);
        chk("reset_b_tready", 32'(b_ready), 32'd1);

        // basic 6.0 / 2.0, both operands in the same cycle
        send_op(32'h40C0_0000, 32'h4000_0000, 0, 0, acap, bcap);
        chk("same_cycle_capture", 32'(bcap), 32'(acap));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("busy_treadys", {30'd0, a_ready, b_ready}, 32'd0);
        end
        wait_result(ops_sent, 0);

        // directed rounding, special and range-limit cases
        for (int i = 0; i < 11; i++) begin
            send_op(dir_a[i], dir_b[i], (i % 3 == 2) ? 2 : 0, (i % 3 == 1) ? 3 : 0, acap, bcap);
            wait_result(ops_sent, 0);
        end

        // a at cycle 0, b at cycle 5
        send_op(32'h40C0_0000, 32'h4000_0000, 0, 5, acap, bcap);
        chk("b_accept_offset", 32'(bcap - acap), 32'd5);
        wait_result(ops_sent, 0);

        // result back-pressure for 10 cycles, then a one-cycle tready pulse
        res_ready = 1'b0;
        send_op(32'h3F80_0000, 32'h4040_0000, 0, 0, acap, bcap);
        for (int t = 0; t < 60 && !m_vld; t++) @(posedge clk);
        if (!m_vld) timeout_fail("stall_tvalid");
        repeat (10) @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("post_transfer_tvalid", 32'(m_vld), 32'd0);
        chk("post_transfer_treadys", {30'd0, a_ready, b_ready}, 32'd3);
        res_ready = 1'b1;

        // reset in the middle of a division
        send_op(32'h40C0_0000, 32'h4000_0000, 0, 0, acap, bcap);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        cap_q.delete();
        ops_sent = ops_sent - 1;
        @(negedge clk);
        chk("midop_reset_tvalid", 32'(m_vld), 32'd0);
        chk("midop_reset_treadys", {30'd0, a_ready, b_ready}, 32'd3);
        send_op(32'h40C0_0000, 32'h4000_0000, 0, 0, acap, bcap);
        wait_result(ops_sent, 0);

        // randomized operands, arrival order and result back-pressure
        for (int i = 0; i < 40; i++) begin
            send_op(rand_operand(), rand_operand(), $urandom_range(0, 3),
                    $urandom_range(0, 3), acap, bcap);
            wait_result(ops_sent, 1);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
